// File: rtl/ternary_host_tx_pkg.sv
// rtl/ternary_host_tx_pkg.sv - shared types and constants for the ternary host transmitter
package ternary_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARST,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  // Two-bit ternary weight codes as packed into each weight row
  localparam logic [1:0] TCODE_ZERO = 2'b00;
  localparam logic [1:0] TCODE_POS  = 2'b01;
  localparam logic [1:0] TCODE_NEG  = 2'b11;

  localparam int         LOAD_WORDS  = 14;
  localparam int         ARST_CYCLES = 2;
  localparam logic [3:0] MIRROR_LAST = 4'd14;

  // Mirror of the accelerator's internal counter: skips every value whose low bits are 7
  function automatic logic [3:0] mirror_next(input logic [3:0] m);
    return (m[2:0] == 3'd6) ? m + 4'd2 : m + 4'd1;
  endfunction

endpackage

// File: rtl/ternary_res_capture.sv
// rtl/ternary_res_capture.sv - result tag pipeline and result byte assembly
module ternary_res_capture
  import ternary_host_tx_pkg::*;
#(
  parameter int OUT_LEN = 7,
  parameter int OUT_LAT = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic [7:0]           acc_uo_out,
  output logic                 res_valid,
  output logic [8*OUT_LEN-1:0] res_data,
  output logic                 pending
);
  // tag_q[k] is high k+1 cycles after a valid frame's row 0; last stage marks the final byte
  localparam int TAG_LEN = OUT_LAT + OUT_LEN - 1;

  logic [TAG_LEN-1:0]   tag_q, tag_d;
  logic [7:0]           byte_q [OUT_LEN-1];
  logic [7:0]           byte_d [OUT_LEN-1];
  logic                 res_valid_q, res_valid_d;
  logic [8*OUT_LEN-1:0] res_data_q, res_data_d;

  // Shift tags, grab each byte in its slot, publish all bytes when the last one arrives
  always_comb begin
    tag_d       = {tag_q[TAG_LEN-2:0], frame_start};
    byte_d      = byte_q;
    res_valid_d = tag_q[TAG_LEN-1];
    res_data_d  = res_data_q;
    for (int j = 0; j < OUT_LEN - 1; j++) begin
      if (tag_q[OUT_LAT-1+j]) byte_d[j] = acc_uo_out;
    end
    if (tag_q[TAG_LEN-1]) begin
      for (int j = 0; j < OUT_LEN - 1; j++) res_data_d[8*j +: 8] = byte_q[j];
      res_data_d[8*(OUT_LEN-1) +: 8] = acc_uo_out;
    end
  end

  // Capture registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      for (int j = 0; j < OUT_LEN - 1; j++) byte_q[j] <= 8'h00;
    end else begin
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      byte_q      <= byte_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign pending   = |tag_q;

endmodule

// File: rtl/ternary_host_tx.sv
// rtl/ternary_host_tx.sv - host-side weight loader and activation streamer for a ternary accelerator
module ternary_host_tx
  import ternary_host_tx_pkg::*;
#(
  parameter int IN_LEN  = 14,
  parameter int OUT_LEN = 7,
  parameter int OUT_LAT = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_we,
  input  logic [3:0]           w_addr,
  input  logic [2*OUT_LEN-1:0] w_data,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic [8*IN_LEN-1:0]  vec_data,
  output logic                 res_valid,
  output logic [8*OUT_LEN-1:0] res_data,
  output logic                 busy,
  output logic                 acc_rst_n,
  output logic [7:0]           acc_ui_in,
  output logic [7:0]           acc_uio_in,
  input  logic [7:0]           acc_uo_out
);
  localparam logic [3:0] ROW_MAX   = 4'(IN_LEN - 1);
  localparam logic [1:0] ARST_LAST = 2'(ARST_CYCLES - 1);

  state_t               state_q, state_d;
  logic [1:0]           arst_cnt_q, arst_cnt_d;
  logic [3:0]           mirror_q, mirror_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [8*IN_LEN-1:0]  buf_data_q, buf_data_d;
  logic [8*IN_LEN-1:0]  frame_q, frame_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 stop_q, stop_d;
  logic [2*OUT_LEN-1:0] wbuf_q [IN_LEN];
  logic [2*OUT_LEN-1:0] wbuf_d [IN_LEN];

  logic       boundary, handshake, frame_start, pending;
  logic [3:0] load_row;
  logic [2:0] row;
  logic [15:0] bus;

  assign row       = mirror_q[2:0];
  assign load_row  = mirror_q[3] ? mirror_q - 4'd1 : mirror_q;
  assign boundary  = ((state_q == ST_LOAD) && (mirror_q == MIRROR_LAST)) ||
                     (((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && (row == 3'd6));
  assign handshake = vec_valid && vec_ready;
  assign frame_start = (state_q == ST_STREAM) && (row == 3'd0) && frame_valid_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: stop only bites at a frame boundary once the skid buffer is empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ARST;
      ST_ARST:   if (arst_cnt_q == ARST_LAST) state_d = ST_LOAD;
      ST_LOAD:   if (boundary) state_d = (stop_q && !buf_valid_q) ? ST_DRAIN : ST_STREAM;
      ST_STREAM: if (boundary && stop_q && !buf_valid_q) state_d = ST_DRAIN;
      ST_DRAIN:  if (!pending) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: accelerator reset, bus word and handshake readiness
  always_comb begin
    acc_rst_n = 1'b0;
    vec_ready = 1'b0;
    bus       = 16'h0000;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_LOAD: begin
        acc_rst_n = 1'b1;
        bus       = {2'b00, wbuf_q[load_row]};
        vec_ready = !buf_valid_q && !stop_q;
      end
      ST_STREAM: begin
        acc_rst_n = 1'b1;
        bus       = {frame_q[{row, 4'b0000} +: 8], frame_q[{row, 4'b1000} +: 8]};
        vec_ready = !buf_valid_q && !stop_q;
      end
      ST_DRAIN: begin
        acc_rst_n = 1'b1;
        bus       = {frame_q[{row, 4'b0000} +: 8], frame_q[{row, 4'b1000} +: 8]};
      end
      default: ;
    endcase
  end

  assign acc_ui_in  = bus[15:8];
  assign acc_uio_in = bus[7:0];

  // Datapath next values: weight writes, mirror counter, skid buffer, frame register, stop latch
  always_comb begin
    arst_cnt_d    = 2'd0;
    mirror_d      = 4'd0;
    buf_valid_d   = buf_valid_q;
    buf_data_d    = buf_data_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    stop_d        = stop_q;
    wbuf_d        = wbuf_q;
    case (state_q)
      ST_IDLE: begin
        buf_valid_d   = 1'b0;
        frame_d       = '0;
        frame_valid_d = 1'b0;
        stop_d        = 1'b0;
        if (w_we && (w_addr <= ROW_MAX)) wbuf_d[w_addr] = w_data;
      end
      ST_ARST: arst_cnt_d = arst_cnt_q + 2'd1;
      default: mirror_d = mirror_next(mirror_q);
    endcase
    if (stop && ((state_q == ST_ARST) || (state_q == ST_LOAD) || (state_q == ST_STREAM)))
      stop_d = 1'b1;
    if (boundary) begin
      frame_d       = buf_valid_q ? buf_data_q : '0;
      frame_valid_d = buf_valid_q;
      buf_valid_d   = 1'b0;
    end
    if (handshake) begin
      buf_valid_d = 1'b1;
      buf_data_d  = vec_data;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arst_cnt_q    <= 2'd0;
      mirror_q      <= 4'd0;
      buf_valid_q   <= 1'b0;
      buf_data_q    <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      stop_q        <= 1'b0;
      for (int i = 0; i < IN_LEN; i++) wbuf_q[i] <= '0;
    end else begin
      arst_cnt_q    <= arst_cnt_d;
      mirror_q      <= mirror_d;
      buf_valid_q   <= buf_valid_d;
      buf_data_q    <= buf_data_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      stop_q        <= stop_d;
      wbuf_q        <= wbuf_d;
    end
  end

  ternary_res_capture #(
    .OUT_LEN (OUT_LEN),
    .OUT_LAT (OUT_LAT)
  ) u_capture (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .acc_uo_out  (acc_uo_out),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .pending     (pending)
  );

endmodule

// File: tb/tb_ternary_host_tx.sv
// tb/tb_ternary_host_tx.sv - directed self-checking bench for ternary_host_tx
module tb_ternary_host_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         w_we;
  logic [3:0]   w_addr;
  logic [13:0]  w_data;
  logic         start, stop;
  logic         vec_valid, vec_ready;
  logic [111:0] vec_data;
  logic         res_valid;
  logic [55:0]  res_data;
  logic         busy, acc_rst_n;
  logic [7:0]   acc_ui_in, acc_uio_in, acc_uo_out;

  int total = 0;
  int bad   = 0;

  localparam logic [55:0] R1 = 56'h1B17130F0B0703;
  localparam logic [55:0] R2 = 56'h3935312D292521;
  localparam logic [55:0] R3 = 56'h7975716D696561;

  logic [111:0] v1, v2, v3;
  logic [7:0]   pipe [7];

  always #5 clk = ~clk;

  ternary_host_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .start      (start),
    .stop       (stop),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_data   (vec_data),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .busy       (busy),
    .acc_rst_n  (acc_rst_n),
    .acc_ui_in  (acc_ui_in),
    .acc_uio_in (acc_uio_in),
    .acc_uo_out (acc_uo_out)
  );

  // Accelerator stand-in: byte out = ui+uio seen 7 cycles earlier, cleared while held in reset
  always @(posedge clk) begin
    if (!acc_rst_n) begin
      for (int i = 0; i < 7; i++) pipe[i] <= 8'h00;
    end else begin
      pipe[0] <= acc_ui_in + acc_uio_in;
      for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign acc_uo_out = pipe[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [111:0] make_vec(input logic [7:0] base);
    logic [111:0] v;
    for (int i = 0; i < 14; i++) v[8*i +: 8] = base + 8'(i);
    return v;
  endfunction

  // Frames from stream start: V1, V2, bubble, V3, then zero drain frames
  function automatic logic [15:0] exp_bus(input int t);
    logic [7:0] base;
    int f, r;
    f = t / 7;
    r = t % 7;
    case (f)
      0: base = 8'h01;
      1: base = 8'h10;
      3: base = 8'h30;
      default: return 16'h0000;
    endcase
    return {base + 8'(2*r), base + 8'(2*r + 1)};
  endfunction

  initial begin
    rst_n = 1'b0; w_we = 1'b0; w_addr = 4'd0; w_data = 14'd0;
    start = 1'b0; stop = 1'b0; vec_valid = 1'b0; vec_data = '0;
    v1 = make_vec(8'h01);
    v2 = make_vec(8'h10);
    v3 = make_vec(8'h30);
    step();
    step();
    chk("rst_acc_rst_n", acc_rst_n, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_vec_ready", vec_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 56'h0);
    chk("rst_bus", {acc_ui_in, acc_uio_in}, 16'h0);
    rst_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      w_we = 1'b1;
      w_addr = 4'(k);
      w_data = (k < 14) ? 14'(14'h0001 << k) : 14'h3FFF;
      step();
    end
    w_we = 1'b0;
    chk("idle_busy", busy, 1'b0);

    // Session 1: load, two back-to-back vectors, a bubble, then a vector together with stop
    start = 1'b1;
    step();
    start = 1'b0;
    chk("arst1_acc_rst_n", acc_rst_n, 1'b0);
    chk("arst1_busy", busy, 1'b1);
    step();
    chk("arst2_acc_rst_n", acc_rst_n, 1'b0);
    vec_valid = 1'b1;
    vec_data = v1;
    step();
    for (int n = 0; n < 14; n++) begin
      chk("load_acc_rst_n", acc_rst_n, 1'b1);
      chk("load_bus", {acc_ui_in, acc_uio_in}, 16'(16'h0001 << n));
      if (n == 1) chk("load_buf_full_ready", vec_ready, 1'b0);
      step();
      if (n == 0) vec_data = v2;
    end

    for (int t = 0; t <= 36; t++) begin
      chk("res_valid", res_valid, (t == 14) || (t == 21) || (t == 35));
      if (t == 14) chk("res_data_v1", res_data, R1);
      if (t == 21) chk("res_data_v2", res_data, R2);
      if (t == 30) chk("res_data_hold", res_data, R2);
      if (t == 35) chk("res_data_v3", res_data, R3);
      if (t == 0)  chk("stream_ready_empty", vec_ready, 1'b1);
      if (t == 15) chk("bubble_ready", vec_ready, 1'b1);
      if (t == 16) chk("stop_pending_ready", vec_ready, 1'b0);
      if (t < 36) begin
        chk("sess_acc_rst_n", acc_rst_n, 1'b1);
        chk("sess_busy", busy, 1'b1);
        chk("sess_bus", {acc_ui_in, acc_uio_in}, exp_bus(t));
      end else begin
        chk("end_acc_rst_n", acc_rst_n, 1'b0);
        chk("end_busy", busy, 1'b0);
        chk("end_bus", {acc_ui_in, acc_uio_in}, 16'h0);
      end
      if (t < 36) begin
        step();
        if (t == 0)  vec_valid = 1'b0;
        if (t == 2)  begin w_we = 1'b1; w_addr = 4'd2; w_data = 14'h3FFF; end
        if (t == 3)  w_we = 1'b0;
        if (t == 4)  start = 1'b1;
        if (t == 5)  start = 1'b0;
        if (t == 14) begin vec_valid = 1'b1; vec_data = v3; stop = 1'b1; end
        if (t == 15) begin vec_valid = 1'b0; stop = 1'b0; end
      end
    end

    // Session 2: original weights reloaded, then reset in the middle of a frame
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    vec_valid = 1'b1;
    vec_data = v1;
    step();
    for (int n = 0; n < 14; n++) begin
      chk("reload_bus", {acc_ui_in, acc_uio_in}, 16'(16'h0001 << n));
      step();
      if (n == 0) vec_valid = 1'b0;
    end
    for (int r = 0; r < 4; r++) begin
      chk("s2_bus", {acc_ui_in, acc_uio_in}, exp_bus(r));
      if (r < 3) step();
    end
    rst_n = 1'b0;
    step();
    chk("mid_rst_acc_rst_n", acc_rst_n, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_vec_ready", vec_ready, 1'b0);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    chk("mid_rst_res_data", res_data, 56'h0);
    chk("mid_rst_bus", {acc_ui_in, acc_uio_in}, 16'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      chk("post_rst_no_res", res_valid, 1'b0);
      step();
    end

    // Session 3: weights were cleared by reset; stop during load drains straight to idle
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    for (int n = 0; n < 14; n++) begin
      chk("zero_load_bus", {acc_ui_in, acc_uio_in}, 16'h0);
      stop = (n == 0);
      step();
    end
    stop = 1'b0;
    for (int c = 0; c < 10 && busy; c++) step();
    chk("s3_idle_busy", busy, 1'b0);
    chk("s3_idle_acc_rst_n", acc_rst_n, 1'b0);
    chk("s3_no_res", res_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ternary_host_tx.md
TERNARY_HOST_TX -- requirements
Module: ternary_host_tx

Interface
REQ-001 SHALL have parameter IN_LEN, default 14, meaning activation lanes per vector and weight rows.
REQ-002 SHALL have parameter OUT_LEN, default 7, meaning result lanes per vector and the frame length in cycles.
REQ-003 SHALL have parameter OUT_LAT, default 7, meaning cycles from frame row 0 driven to result byte 0 sampled.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 w_we / w_addr / w_data  in  1/4/14  weight-buffer write; row w_addr holds 7 two-bit ternary codes.
REQ-007 start / stop  in  1/1  single-cycle session start and stop requests.
REQ-008 vec_valid / vec_ready / vec_data  in/out/in  1/1/112  activation handshake; lane i is vec_data[8i+7:8i].
REQ-009 res_valid / res_data  out  1/56  one-cycle result strobe; lane j is res_data[8j+7:8j].
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 acc_rst_n / acc_ui_in / acc_uio_in  out  1/8/8  drive to the accelerator's rst_n, ui_in, uio_in.
REQ-012 acc_uo_out  in  8  accelerator result byte.

Function
REQ-013 States: IDLE, ARST, LOAD, STREAM, DRAIN.
REQ-014 IDLE: acc_rst_n=0, bus=0; w_we writes weight row w_addr (w_addr>13 ignored); start -> ARST.
REQ-015 w_we outside IDLE SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-016 ARST: acc_rst_n=0 for exactly 2 cycles, then -> LOAD with acc_rst_n=1 from the first LOAD cycle onward.
REQ-017 A 4-bit mirror counter SHALL be cleared in ARST and advance per cycle by +2 when its low 3 bits equal 6, else +1 (sequence 0..6, 8..14, 0).
REQ-018 LOAD: 14 cycles; at mirror value c the bus {acc_ui_in,acc_uio_in} SHALL carry {2'b00, weight row k}, k = c for c<7, k = c-1 for c>=8.
REQ-019 After mirror value 14 -> STREAM; frame row r = mirror[2:0], 0..6.
REQ-020 STREAM row r: acc_ui_in = lane 2r, acc_uio_in = lane 2r+1 of the frame register.
REQ-021 One-entry skid buffer: vec_ready = buffer empty and state in {LOAD, STREAM} and no stop pending.
REQ-022 At the cycle before each row 0, the buffer moves into the frame register and tags the frame valid; empty buffer -> zero frame tagged invalid (bubble).
REQ-023 Result byte j of a valid frame SHALL be sampled from acc_uo_out OUT_LAT+j cycles after that frame's row 0.
REQ-024 res_valid SHALL pulse one cycle after byte 6 is sampled, with all 7 bytes on res_data; bubbles produce no pulse.
REQ-025 res_data SHALL hold its last value until the next res_valid.
REQ-026 stop SHALL be latched; it takes effect at the next frame boundary, where a buffered vector is still sent, then -> DRAIN.
REQ-027 DRAIN: drive zero frames until the last valid frame's result pulses, then -> IDLE (acc_rst_n=0).
REQ-028 Simultaneous stop and vec_valid handshake: the vector SHALL be accepted and streamed before stopping.

Reset
REQ-029 rst_n=0 SHALL force IDLE, acc_rst_n=0, bus=0, res_valid=0, res_data=0, vec_ready=0, busy=0, empty buffer, cleared stop latch and tags.
REQ-030 Weight buffer contents SHALL be cleared to zero by reset.
REQ-031 Reset mid-session SHALL abort within one cycle without emitting res_valid.

Structure
REQ-032 Shared package SHALL hold the state enum, ternary codes (00=0, 01=+1, 11=-1), LOAD_WORDS=14, ARST_CYCLES=2.
REQ-033 One sub-module ternary_res_capture SHALL hold the result tag pipeline and byte assembly.

Verification
REQ-034 Weights row k = 14'h0001<<k, start -> 2 cycles acc_rst_n=0, then 14 bus words matching REQ-018, then STREAM.
REQ-035 Two back-to-back vectors, lanes = i+1 -> rows drive {8'h01,8'h02}..{8'h0D,8'h0E}; behavioural accelerator model results match, two res_valid pulses 7 cycles apart.
REQ-036 vec_valid low for one frame -> zero bubble frame, no res_valid for it, next valid result pulse 14 cycles after the previous.
REQ-037 stop in the same cycle as a handshake -> vector streamed, its result pulses, then IDLE with acc_rst_n=0 and busy=0.
REQ-038 rst_n low mid-STREAM at row 3 -> all outputs at reset values next cycle, no res_valid; restart reloads zero weights.
REQ-039 w_we during STREAM with w_addr=2, w_data=14'h3FFF -> buffer unchanged, next session reloads the original row 2.
